// File: rtl/vscale_hasti_loader_pkg.sv
// vscale_hasti_loader_pkg
//   HASTI (AHB-Lite) encodings and widths used by the program loader, plus the
//   loader FSM state codes.
package vscale_hasti_loader_pkg;

    // HASTI bus widths
    localparam int HASTI_ADDR_WIDTH  = 32;
    localparam int HASTI_BUS_WIDTH   = 32;
    localparam int HASTI_SIZE_WIDTH  = 3;
    localparam int HASTI_BURST_WIDTH = 3;
    localparam int HASTI_PROT_WIDTH  = 4;
    localparam int HASTI_TRANS_WIDTH = 2;
    localparam int HASTI_RESP_WIDTH  = 1;

    // HASTI encodings
    localparam logic [HASTI_SIZE_WIDTH-1:0]  HASTI_SIZE_WORD      = 3'd2;
    localparam logic [HASTI_BURST_WIDTH-1:0] HASTI_BURST_SINGLE   = 3'd0;
    localparam logic [HASTI_PROT_WIDTH-1:0]  HASTI_NO_PROT        = 4'd0;
    localparam logic                         HASTI_MASTER_NO_LOCK = 1'b0;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE     = 2'd0;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ   = 2'd2;
    localparam logic [HASTI_RESP_WIDTH-1:0]  HASTI_RESP_ERROR     = 1'b1;

    // Loader FSM state codes
    localparam logic [2:0] LD_IDLE  = 3'd0;
    localparam logic [2:0] LD_LOAD  = 3'd1;
    localparam logic [2:0] LD_DRAIN = 3'd2;
    localparam logic [2:0] LD_DONE  = 3'd3;
    localparam logic [2:0] LD_ERR   = 3'd4;

endpackage

// File: rtl/vscale_hasti_loader.sv
// vscale_hasti_loader
//   HASTI write-only initiator that copies a program image from a valid/ready
//   word stream into memory, holding the core in reset until the load finishes.
//   Single-beat NONSEQ transfers with pipelined address/data phases, one word
//   per cycle when the source and the bus both keep up.
// Ports
//   clk, reset            clock, synchronous active-high reset
//   start                 begin a load (ignored while busy)
//   base_addr, word_count load destination (word aligned) and length in words
//   in_valid/in_ready/in_data   word source handshake
//   haddr..hwdata         HASTI initiator outputs
//   hrdata, hready, hresp HASTI responder inputs (hrdata unused)
//   busy, done, error     status levels
//   core_reset            held high except after a successful load
module vscale_hasti_loader
    import vscale_hasti_loader_pkg::*;
#(
    parameter int COUNT_WIDTH = 16,
    parameter int ADDR_WIDTH  = HASTI_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [COUNT_WIDTH-1:0]       word_count,
    input  logic                         in_valid,
    input  logic [HASTI_BUS_WIDTH-1:0]   in_data,
    output logic                         in_ready,
    output logic [ADDR_WIDTH-1:0]        haddr,
    output logic                         hwrite,
    output logic [HASTI_SIZE_WIDTH-1:0]  hsize,
    output logic [HASTI_BURST_WIDTH-1:0] hburst,
    output logic                         hmastlock,
    output logic [HASTI_PROT_WIDTH-1:0]  hprot,
    output logic [HASTI_TRANS_WIDTH-1:0] htrans,
    output logic [HASTI_BUS_WIDTH-1:0]   hwdata,
    input  logic [HASTI_BUS_WIDTH-1:0]   hrdata,
    input  logic                         hready,
    input  logic [HASTI_RESP_WIDTH-1:0]  hresp,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic                         core_reset
);

    logic [2:0]                 state;
    logic [ADDR_WIDTH-1:0]      base;
    logic [COUNT_WIDTH-1:0]     count;
    logic [COUNT_WIDTH-1:0]     issued;
    logic [COUNT_WIDTH-1:0]     completed;
    logic [COUNT_WIDTH-1:0]     completed_next;
    logic [HASTI_BUS_WIDTH-1:0] a_data;
    logic                       dvalid;
    logic                       launch;
    logic                       accept;
    logic                       bus_error;
    logic                       unused_hrdata;

    assign unused_hrdata = ^hrdata;

    // Fixed transfer attributes: single word writes, no lock, no protection.
    assign hsize     = HASTI_SIZE_WORD;
    assign hburst    = HASTI_BURST_SINGLE;
    assign hmastlock = HASTI_MASTER_NO_LOCK;
    assign hprot     = HASTI_NO_PROT;
    assign hwrite    = (htrans == HASTI_TRANS_NONSEQ);

    assign busy       = (state == LD_LOAD) || (state == LD_DRAIN);
    assign done       = (state == LD_DONE) || (state == LD_ERR);
    assign error      = (state == LD_ERR);
    assign core_reset = (state != LD_DONE);

    // in_ready deliberately ignores in_valid so the source may wait on it.
    assign in_ready = (state == LD_LOAD) && hready && (issued < count);
    assign accept   = in_valid && in_ready;
    assign launch   = start && !busy;

    // First cycle of a two-cycle ERROR response: data phase stalled with ERROR.
    // Later ERROR cycles land outside LOAD/DRAIN and are ignored.
    assign bus_error = busy && dvalid && !hready && (hresp == HASTI_RESP_ERROR);

    assign completed_next = completed + COUNT_WIDTH'(dvalid);

    // Control: state and the latched load descriptor.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LD_IDLE;
            base  <= '0;
            count <= '0;
        end else if (launch) begin
            base  <= {base_addr[ADDR_WIDTH-1:2], 2'b00};
            count <= word_count;
            state <= (word_count == '0) ? LD_DONE : LD_LOAD;
        end else if (bus_error) begin
            state <= LD_ERR;
        end else begin
            case (state)
                LD_LOAD:  if (issued == count) state <= LD_DRAIN;
                // Leave DRAIN on the edge that retires the final data phase.
                LD_DRAIN: if (hready && dvalid && (completed_next == count)) state <= LD_DONE;
                default:  ;
            endcase
        end
    end

    // Bus pipeline: address phase {htrans, haddr, a_data} feeds data phase
    // {dvalid, hwdata}. Everything holds while hready is low so a NONSEQ is
    // only ever withdrawn by an ERROR response.
    always_ff @(posedge clk) begin
        if (reset) begin
            htrans    <= HASTI_TRANS_IDLE;
            haddr     <= '0;
            a_data    <= '0;
            dvalid    <= 1'b0;
            hwdata    <= '0;
            issued    <= '0;
            completed <= '0;
        end else if (launch) begin
            htrans    <= HASTI_TRANS_IDLE;
            dvalid    <= 1'b0;
            issued    <= '0;
            completed <= '0;
        end else if (bus_error) begin
            htrans <= HASTI_TRANS_IDLE;
        end else if (hready) begin
            dvalid    <= (htrans == HASTI_TRANS_NONSEQ);
            hwdata    <= a_data;
            completed <= completed_next;
            if (accept) begin
                htrans <= HASTI_TRANS_NONSEQ;
                // Address wraps naturally at ADDR_WIDTH.
                haddr  <= base + (ADDR_WIDTH'(issued) << 2);
                a_data <= in_data;
                issued <= issued + COUNT_WIDTH'(1);
            end else begin
                htrans <= HASTI_TRANS_IDLE;
            end
        end
    end

endmodule
